// File: rtl/regfile_write_arbiter_pkg.sv
// Shared pipeline definitions for the register-file writeback path:
// default widths and the requester index encoding.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per architectural register, set at
// issue, cleared at writeback, with two combinational read ports.
module regfile_scoreboard
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rd_idx1,
  input  logic [ADDR_W-1:0] rd_idx2,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Set is applied after clear so a newer producer issued in the same
  // cycle as an older writeback keeps the register marked pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy1 = busy_q[rd_idx1];
  assign busy2 = busy_q[rd_idx2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load unit) round-robin arbiter for the single
// register-file write port, plus the pending-write scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  output logic              busy1,
  output logic              busy2
);

  // Handshake: a request transfers in exactly the cycle where its valid and
  // ready are both high; ready depends only on the valids, the priority
  // pointer and reset, and a held requester keeps its inputs stable.
  req_idx_t          prio;
  logic              grant_alu;
  logic              grant_mem;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    grant_alu = reset_n && alu_valid && (!mem_valid || (prio == REQ_ALU));
    grant_mem = reset_n && mem_valid && (!alu_valid || (prio == REQ_MEM));
    grant_any = grant_alu || grant_mem;
    sel_reg   = grant_mem ? mem_reg  : alu_reg;
    sel_data  = grant_mem ? mem_data : alu_data;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Pointer always moves to the requester that was not granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio <= REQ_ALU;
    end else if (grant_alu) begin
      prio <= REQ_MEM;
    end else if (grant_mem) begin
      prio <= REQ_ALU;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regwrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
    end else begin
      regwrite <= grant_any && (sel_reg != '0);
      if (grant_any) begin
        writereg  <= sel_reg;
        writedata <= sel_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (issue_valid),
    .set_idx (issue_reg),
    .clr_en  (grant_any),
    .clr_idx (sel_reg),
    .rd_idx1 (readreg1),
    .rd_idx2 (readreg2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table for arbitration plus
// hand-written sequences for contention, scoreboard and mid-cycle reset.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int OW = 1 + AW + DW;

  logic          clock;
  logic          reset_n;
  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_reg;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          regwrite;
  logic [AW-1:0] writereg;
  logic [DW-1:0] writedata;
  logic          issue_valid;
  logic [AW-1:0] issue_reg;
  logic [AW-1:0] readreg1;
  logic [AW-1:0] readreg2;
  logic          busy1;
  logic          busy2;

  regfile_write_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_reg     (alu_reg),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_reg     (mem_reg),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .regwrite    (regwrite),
    .writereg    (writereg),
    .writedata   (writedata),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .readreg1    (readreg1),
    .readreg2    (readreg2),
    .busy1       (busy1),
    .busy2       (busy2)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] last_reg;
  logic [DW-1:0] last_data;

  typedef struct {
    logic          av;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] mr;
    logic [DW-1:0] md;
    logic          ea;
    logic          em;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected port contents one edge later, from the bench's own view of
  // which requester should win this cycle.
  task automatic push_exp(input logic ea, input logic em);
    logic [AW-1:0] r;
    logic          w;
    w = 1'b0;
    if (ea || em) begin
      r         = ea ? alu_reg : mem_reg;
      last_reg  = r;
      last_data = ea ? alu_data : mem_data;
      w         = (r != '0);
    end
    exp_q.push_back({w, last_reg, last_data});
  endtask

  task automatic pop_cmp(input string tag);
    logic [OW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue actual=empty required=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_regwrite"}, 64'(regwrite), 64'(e[OW-1]));
    chk({tag, "_writereg"}, 64'(writereg), 64'(e[OW-2 -: AW]));
    chk({tag, "_writedata"}, 64'(writedata), 64'(e[DW-1:0]));
  endtask

  // driver: called at posedge+1 with inputs already applied
  task automatic step(input string tag, input logic ea, input logic em,
                      input logic cb, input logic b1, input logic b2);
    #3;
    chk({tag, "_alu_ready"}, 64'(alu_ready), 64'(ea));
    chk({tag, "_mem_ready"}, 64'(mem_ready), 64'(em));
    if (cb) begin
      chk({tag, "_busy1"}, 64'(busy1), 64'(b1));
      chk({tag, "_busy2"}, 64'(busy2), 64'(b2));
    end
    push_exp(ea, em);
    @(posedge clock);
    #1;
    pop_cmp(tag);
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #2;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_writereg", 64'(writereg), 64'd0);
    chk("rst_writedata", 64'(writedata), 64'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset_n = 1'b1;
    exp_q.delete();
    last_reg  = '0;
    last_data = '0;
  endtask

  initial begin
    reset_n     = 1'b0;
    alu_valid   = 1'b0;
    alu_reg     = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_reg     = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
    readreg1    = '0;
    readreg2    = '0;
    last_reg    = '0;
    last_data   = '0;

    // pointer starts at ALU after reset; expectations follow round-robin by hand
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd3,  32'h1111_0003, 1'b1, 5'd4, 32'h2222_0004, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 5'd3,  32'h1111_0003, 1'b1, 5'd6, 32'h2222_0006, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hCAFE_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  $urandom,     1'b0, 1'b1};
    vecs[6] = '{1'b1, 5'd10, $urandom,     1'b1, 5'd11, $urandom,     1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'd10, $urandom,     1'b1, 5'd12, $urandom,     1'b0, 1'b1};
    vecs[8] = '{1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      alu_valid = vecs[i].av;
      alu_reg   = vecs[i].ar;
      alu_data  = vecs[i].ad;
      mem_valid = vecs[i].mv;
      mem_reg   = vecs[i].mr;
      mem_data  = vecs[i].md;
      step($sformatf("vec%0d", i), vecs[i].ea, vecs[i].em, 1'b0, 1'b0, 1'b0);
    end
    idle_inputs();

    // contention straight after reset: ALU, MEM, then ALU again
    do_reset();
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA0A0_0003;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hB0B0_0004;
    step("cont0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_data = 32'hA0A0_1003;
    step("cont1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_data = 32'hB0B0_1004;
    step("cont2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_inputs();

    // busy vector: set, clear by grant, set+clear collision, bit 0, idle write
    do_reset();
    issue_valid = 1'b1; issue_reg = 5'd7; readreg1 = 5'd7; readreg2 = 5'd0;
    step("sb0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h0000_0707;
    step("sb1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    alu_valid = 1'b0;
    step("sb2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_valid = 1'b1; issue_reg = 5'd7;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h0000_1707;
    step("sb3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    alu_valid = 1'b0; issue_reg = 5'd0;
    step("sb4", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd12; mem_data = 32'h0000_0C0C;
    step("sb5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_inputs();

    // asynchronous reset in the middle of a pending grant
    do_reset();
    issue_valid = 1'b1; issue_reg = 5'd2;
    step("ar0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_reg = 5'd9;
    step("ar1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h5555_AAAA;
    step("ar2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_reg = 5'd2; alu_data = 32'h2222_2222;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h9999_9999;
    issue_valid = 1'b1; issue_reg = 5'd20;
    readreg1 = 5'd2; readreg2 = 5'd9;
    #2;
    chk("ar3_busy1", 64'(busy1), 64'd1);
    chk("ar3_busy2", 64'(busy2), 64'd1);
    chk("ar3_mem_ready", 64'(mem_ready), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_rst_regwrite", 64'(regwrite), 64'd0);
    chk("ar_rst_writereg", 64'(writereg), 64'd0);
    chk("ar_rst_writedata", 64'(writedata), 64'd0);
    chk("ar_rst_busy1", 64'(busy1), 64'd0);
    chk("ar_rst_busy2", 64'(busy2), 64'd0);
    chk("ar_rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("ar_rst_mem_ready", 64'(mem_ready), 64'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset_n = 1'b1;
    readreg1 = 5'd20;
    exp_q.delete();
    last_reg  = '0;
    last_data = '0;
    step("ar_post0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ar_post1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the writeback data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register index width; the register count SHALL be 2**ADDR_W.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 alu_valid/alu_reg/alu_data  input  1/ADDR_W/DATA_W  SHALL carry the ALU writeback request.
REQ-006 alu_ready  output  1  SHALL accept the ALU request.
REQ-007 mem_valid/mem_reg/mem_data  input  1/ADDR_W/DATA_W  SHALL carry the load-unit writeback request.
REQ-008 mem_ready  output  1  SHALL accept the load-unit request.
REQ-009 regwrite/writereg/writedata  output  1/ADDR_W/DATA_W  SHALL drive the register-file write port.
REQ-010 issue_valid/issue_reg  input  1/ADDR_W  SHALL mark a destination register pending at instruction issue.
REQ-011 readreg1/readreg2  input  ADDR_W each  SHALL be the source indices to check.
REQ-012 busy1/busy2  output  1 each  SHALL flag a pending write to readreg1/readreg2.

Function
REQ-013 A request SHALL transfer only in a cycle where valid and ready are both high; ready SHALL be combinational from the valids and the priority pointer.
REQ-014 With one requester valid, that requester SHALL be granted (ready high); the other ready SHALL be low.
REQ-015 With both valid, the requester named by the priority pointer SHALL be granted and the other held (ready low, inputs held stable by the requester).
REQ-016 The priority pointer SHALL be 1 bit (0 = ALU preferred); after any grant it SHALL point to the non-granted requester, giving round-robin under contention.
REQ-017 A granted transfer SHALL appear on regwrite/writereg/writedata on the next rising edge (latency 1, registered), held for exactly one cycle.
REQ-018 A granted transfer with register index 0 SHALL be accepted but SHALL leave regwrite low.
REQ-019 With no grant in a cycle, regwrite SHALL be low in the following cycle; writereg/writedata SHALL hold their last values.
REQ-020 A 2**ADDR_W-bit busy vector SHALL set bit issue_reg on issue_valid when issue_reg != 0.
REQ-021 A granted transfer SHALL clear the busy bit of its register index on the grant edge.
REQ-022 Simultaneous set and clear of the same bit SHALL leave it set (the newer producer wins).
REQ-023 Busy bit 0 SHALL be constant 0.
REQ-024 busy1/busy2 SHALL be combinational reads of the busy vector at readreg1/readreg2, reflecting the state before the current edge.
REQ-025 A transfer to a register that is not busy SHALL still be written, with no error.

Reset
REQ-026 Asserting reset_n low SHALL immediately force: busy vector 0, priority pointer 0, regwrite 0, writereg 0, writedata 0.
REQ-027 While reset_n is low, alu_ready and mem_ready SHALL be 0 and issue_valid SHALL be ignored.
REQ-028 Reset asserted mid-transfer SHALL discard the transfer; no write SHALL reach the port after reset release without a new handshake.

Structure
REQ-029 DATA_W and ADDR_W defaults and the requester-index encoding (ALU=0, MEM=1) SHALL live in a shared pipeline package.
REQ-030 The busy vector SHALL be a sub-module named regfile_scoreboard (set, clear and two read ports); arbitration and output registers SHALL stay in the top module.

Verification
REQ-031 ALU only: alu_valid=1, alu_reg=5, alu_data=32'hDEADBEEF -> alu_ready=1 in the same cycle; the next cycle regwrite=1, writereg=5, writedata=32'hDEADBEEF.
REQ-032 Contention after reset: both valid, alu_reg=3, mem_reg=4 -> ALU granted in cycle 0 and MEM in cycle 1; writes to 3 then 4 on consecutive cycles; pointer back to 0.
REQ-033 Register 0: mem_valid=1, mem_reg=0 -> mem_ready=1; next cycle regwrite=0.
REQ-034 Scoreboard: issue_reg=7, then readreg1=7 -> busy1=1; ALU grant to 7 -> busy1=0 the next cycle; same-cycle issue_reg=7 plus grant to 7 -> busy1 stays 1.
REQ-035 Reset mid-op: busy bits 2 and 9 set, grant pending, drop reset_n asynchronously -> regwrite, all busy bits and both readys 0 before the next clock edge; no write after release.
